// File: rtl/risc16_pkg.sv
// Shared types and constants for the RISC_16 instruction feeder.
package risc16_pkg;

  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } feeder_state_t;

endpackage

// File: rtl/risc16_prog_ram.sv
// Program store: one write port, one registered read port, contents not reset.
module risc16_prog_ram
  import risc16_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic               re_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] rdata_q;

  // Read data is held between reads so the fetched word stays stable for a whole instruction.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/risc16_instr_feeder.sv
// Sequences a stored program into the RISC_16 core: fetch, enabled run window,
// idle gap with display capture, and a done pulse at the end of the program.
module risc16_instr_feeder
  import risc16_pkg::*;
#(
  parameter int PROG_DEPTH       = 16,
  parameter int CYCLES_PER_INSTR = 5,
  parameter int GAP_CYCLES       = 4,
  localparam int ADDR_W          = $clog2(PROG_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_waddr,
  input  logic [INSTR_W-1:0] prog_wdata,
  input  logic [INSTR_W-1:0] display_in,
  output logic [INSTR_W-1:0] instruction,
  output logic               proc_enable,
  output logic               result_valid,
  output logic [INSTR_W-1:0] result_data,
  output logic [ADDR_W-1:0]  result_index,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done
);

  localparam int CNT_MAX = (CYCLES_PER_INSTR > GAP_CYCLES) ? CYCLES_PER_INSTR : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  feeder_state_t      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic               show_q, show_d;
  logic               proc_enable_q, proc_enable_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rv_q, rv_d;
  logic [INSTR_W-1:0] res_data_q, res_data_d;
  logic [ADDR_W-1:0]  res_idx_q, res_idx_d;
  logic [ADDR_W:0]    len_clamped;
  logic [ADDR_W:0]    pc_next_ext;
  logic [INSTR_W-1:0] ram_rdata;

  assign len_clamped = (prog_len > (ADDR_W+1)'(PROG_DEPTH)) ? (ADDR_W+1)'(PROG_DEPTH) : prog_len;
  assign pc_next_ext = {1'b0, pc_q} + (ADDR_W+1)'(1);

  risc16_prog_ram #(
    .DEPTH  (PROG_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (prog_we && (state_q == ST_IDLE)),
    .waddr_i (prog_waddr),
    .wdata_i (prog_wdata),
    .re_i    (state_q == ST_LOAD),
    .raddr_i (pc_q),
    .rdata_o (ram_rdata)
  );

  // Next-state logic; output registers are loaded from the next state so every output is a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    len_d   = len_q;
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_W'(0);
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            len_d   = len_clamped;
            pc_d    = ADDR_W'(0);
            cnt_d   = CNT_W'(0);
            state_d = (len_clamped == (ADDR_W+1)'(0)) ? ST_DONE : ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          state_d = ST_RUN;
          cnt_d   = CNT_W'(0);
        end
        ST_RUN: begin
          if (cnt_q == CNT_W'(CYCLES_PER_INSTR - 1)) begin
            state_d = ST_GAP;
            cnt_d   = CNT_W'(0);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
            cnt_d = CNT_W'(0);
            // Compare one bit wider so the last entry of a full memory ends the run instead of wrapping.
            if (pc_next_ext < len_q) begin
              pc_d    = pc_q + ADDR_W'(1);
              state_d = ST_LOAD;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    proc_enable_d = (state_d == ST_RUN);
    show_d        = (state_d == ST_RUN) || (state_d == ST_GAP);
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_DONE);
    rv_d          = (state_q == ST_RUN) && (state_d == ST_GAP);
    res_data_d    = rv_d ? display_in : res_data_q;
    res_idx_d     = rv_d ? pc_q : res_idx_q;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= CNT_W'(0);
      pc_q          <= ADDR_W'(0);
      len_q         <= (ADDR_W+1)'(0);
      show_q        <= 1'b0;
      proc_enable_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rv_q          <= 1'b0;
      res_data_q    <= NOP_INSTR;
      res_idx_q     <= ADDR_W'(0);
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pc_q          <= pc_d;
      len_q         <= len_d;
      show_q        <= show_d;
      proc_enable_q <= proc_enable_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rv_q          <= rv_d;
      res_data_q    <= res_data_d;
      res_idx_q     <= res_idx_d;
    end
  end

  assign instruction  = show_q ? ram_rdata : NOP_INSTR;
  assign proc_enable  = proc_enable_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result_valid = rv_q;
  assign result_data  = res_data_q;
  assign result_index = res_idx_q;
  assign pc           = pc_q;

endmodule

// File: tb/tb_risc16_instr_feeder.sv
// Self-checking bench: per-cycle expectations derived from the program timeline arithmetic.
module tb_risc16_instr_feeder;

  localparam int DEPTH = 16;
  localparam int C     = 5;
  localparam int G     = 4;
  localparam int P     = 1 + C + G;

  logic        clk = 1'b0;
  logic        rst, start, abort, prog_we;
  logic [4:0]  prog_len;
  logic [3:0]  prog_waddr;
  logic [15:0] prog_wdata, display_in;
  logic [15:0] instruction, result_data;
  logic        proc_enable, result_valid, busy, done;
  logic [3:0]  result_index, pc;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] mem_m [DEPTH];
  logic [15:0] exp_data;
  int          exp_idx;

  risc16_instr_feeder dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .prog_len(prog_len),
    .prog_we(prog_we), .prog_waddr(prog_waddr), .prog_wdata(prog_wdata),
    .display_in(display_in), .instruction(instruction), .proc_enable(proc_enable),
    .result_valid(result_valid), .result_data(result_data), .result_index(result_index),
    .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_instr"}, instruction, 0);
    chk({tag, "_pe"}, proc_enable, 0);
    chk({tag, "_rv"}, result_valid, 0);
    chk({tag, "_rdata"}, result_data, 0);
    chk({tag, "_ridx"}, result_index, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    logic [31:0] av;
    av = a;
    prog_we = 1'b1; prog_waddr = av[3:0]; prog_wdata = d;
    @(negedge clk);
    prog_we = 1'b0;
    mem_m[a] = d;
  endtask

  // One program run; t counts cycles after the start edge (t=1 is the first fetch cycle).
  task automatic run(input int len_in, input int abort_at, input int we_at,
                     input int rst_at, input int start_at, input bit beef);
    int n, last_t, i, ph;
    logic [15:0] pending, e_instr;
    logic e_pe, e_rv, e_busy, e_done;
    int e_pc;
    logic [31:0] lv;
    lv = len_in;
    n = (len_in > DEPTH) ? DEPTH : len_in;
    last_t = n * P + 2;
    pending = 16'h0000;
    prog_len = lv[4:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; t <= last_t; t++) begin
      start = 1'b0; prog_we = 1'b0; abort = 1'b0;
      i = 0; ph = 0;
      if (n > 0 && t <= n * P) begin
        i = (t - 1) / P; ph = (t - 1) % P;
        e_instr = (ph >= 1) ? mem_m[i] : 16'h0000;
        e_pe = (ph >= 1 && ph <= C);
        e_rv = (ph == C + 1);
        e_pc = i; e_busy = 1'b1; e_done = 1'b0;
        if (e_rv) begin exp_idx = i; exp_data = pending; end
      end else begin
        e_instr = 16'h0000; e_pe = 1'b0; e_rv = 1'b0;
        e_pc = (n > 0) ? n - 1 : 0;
        e_busy = (t == n * P + 1);
        e_done = (t == n * P + 1);
      end
      chk("instruction", instruction, e_instr);
      chk("proc_enable", proc_enable, e_pe);
      chk("result_valid", result_valid, e_rv);
      chk("result_index", result_index, exp_idx);
      chk("result_data", result_data, exp_data);
      chk("pc", pc, e_pc);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      if (beef && e_rv && i == 1) begin
        chk("beef_data", result_data, 16'hBEEF);
        chk("beef_index", result_index, 1);
      end
      if (t == rst_at) begin
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        exp_idx = 0; exp_data = 16'h0000;
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        break;
      end
      if (t == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_pe", proc_enable, 0);
        chk("abort_instr", instruction, 0);
        chk("abort_busy", busy, 0);
        for (int k = 0; k < P + 2; k++) begin
          chk("abort_rv", result_valid, 0);
          chk("abort_done", done, 0);
          chk("abort_ridx", result_index, exp_idx);
          @(negedge clk);
        end
        break;
      end
      if (t == we_at) begin
        prog_we = 1'b1; prog_waddr = 4'd0; prog_wdata = 16'hFFFF;
      end
      if (t == start_at) start = 1'b1;
      if (beef) display_in = (i == 1 && ph >= 1 && ph <= C) ? 16'hBEEF : 16'h0000;
      else display_in = 16'($urandom);
      if (ph == C) pending = display_in;
      @(negedge clk);
    end
    start = 1'b0; prog_we = 1'b0; abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; prog_we = 1'b0; prog_len = 5'd0;
    prog_waddr = 4'd0; prog_wdata = 16'h0000; display_in = 16'h0000;
    exp_idx = 0; exp_data = 16'h0000;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset");

    wr(0, 16'h1001); wr(1, 16'h2002); wr(2, 16'h3003);
    run(3, 0, 0, 0, 0, 1'b1);
    run(0, 0, 0, 0, 0, 1'b0);
    run(3, P + 4, 0, 0, 0, 1'b0);
    run(3, 0, 5, 0, 7, 1'b0);
    run(3, 0, 0, 0, 0, 1'b0);

    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_pe", proc_enable, 0);
    @(negedge clk);
    chk("start_abort_busy2", busy, 0);

    run(3, 0, 0, 8, 0, 1'b0);
    run(3, 0, 0, 0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < DEPTH; a++) wr(a, 16'($urandom));
      run(int'($urandom_range(1, 31)), 0, 0, 0, int'($urandom_range(2, P)), 1'b0);
    end
    run(17, 0, 0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
